fsm_control: RTL

Main control state machine of the switch's output stage. It sits directly upstream of the word-count block, to which it supplies the `IDLE` flag, and it holds the almost-full and almost-empty thresholds used by the output FIFOs. It reads each FIFO's empty and overflow-error flags. From these it sequences RESET → INIT → IDLE ⇄ ACTIVE, and ends in a sticky ERROR state when any FIFO overflows.

---
 rtl/fsm_control.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fsm_control.sv
`default_nettype none
// ============================================================================
// Module   : fsm_control
// Purpose  : Output-stage control FSM (RESET -> INIT -> IDLE <-> ACTIVE, sticky
//            ERROR) holding the FIFO almost-full / almost-empty thresholds.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_control #(
    parameter int N_FIFOS         = 4,
    parameter int INDEX           = 2,
    parameter int TH_WIDTH        = 3,
    parameter int UMBRAL_ALTO_DEF = 6,
    parameter int UMBRAL_BAJO_DEF = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [TH_WIDTH-1:0] umbral_alto_in,
    input  logic [TH_WIDTH-1:0] umbral_bajo_in,
    input  logic [N_FIFOS-1:0]  fifo_empty,
    input  logic [N_FIFOS-1:0]  fifo_error,
    output logic [4:0]          state,
    output logic [TH_WIDTH-1:0] umbral_alto,
    output logic [TH_WIDTH-1:0] umbral_bajo,
    output logic                IDLE,
    output logic                active,
    output logic                error_out,
    output logic [INDEX-1:0]    error_idx,
    output logic                th_invalid
);

    localparam logic [4:0] c_ST_RESET  = 5'b00001;
    localparam logic [4:0] c_ST_INIT   = 5'b00010;
    localparam logic [4:0] c_ST_IDLE   = 5'b00100;
    localparam logic [4:0] c_ST_ACTIVE = 5'b01000;
    localparam logic [4:0] c_ST_ERROR  = 5'b10000;

    localparam logic [TH_WIDTH-1:0] c_ALTO_DEF = TH_WIDTH'(UMBRAL_ALTO_DEF);
    localparam logic [TH_WIDTH-1:0] c_BAJO_DEF = TH_WIDTH'(UMBRAL_BAJO_DEF);

    logic [4:0]          r_state;
    logic [4:0]          w_state_next;
    logic [TH_WIDTH-1:0] r_umbral_alto;
    logic [TH_WIDTH-1:0] r_umbral_bajo;
    logic [INDEX-1:0]    r_error_idx;
    logic                r_th_invalid;

    logic                w_any_error;
    logic                w_all_empty;
    logic                w_in_init;
    logic                w_pair_ok;
    logic                w_load;
    logic                w_reject;
    logic                w_err_entry;
    logic [INDEX-1:0]    w_lowest_err;

    assign w_any_error = |fifo_error;
    assign w_all_empty = &fifo_empty;
    assign w_in_init   = (r_state == c_ST_INIT);
    assign w_pair_ok   = (umbral_bajo_in < umbral_alto_in);
    assign w_load      = w_in_init && init && w_pair_ok;
    assign w_reject    = w_in_init && init && !w_pair_ok;
    assign w_err_entry = ((r_state == c_ST_IDLE) || (r_state == c_ST_ACTIVE)) && w_any_error;

    // Scan from the top so the lowest set bit is the one left standing.
    always_comb begin
        w_lowest_err = '0;
        for (int i = N_FIFOS - 1; i >= 0; i--) begin
            if (fifo_error[i]) begin
                w_lowest_err = INDEX'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RESET: begin
                w_state_next = c_ST_INIT;
            end
            c_ST_INIT: begin
                if (!init) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (w_any_error) begin
                    w_state_next = c_ST_ERROR;
                end else if (init) begin
                    w_state_next = c_ST_INIT;
                end else if (!w_all_empty) begin
                    w_state_next = c_ST_ACTIVE;
                end
            end
            c_ST_ACTIVE: begin
                if (w_any_error) begin
                    w_state_next = c_ST_ERROR;
                end else if (init) begin
                    w_state_next = c_ST_INIT;
                end else if (w_all_empty) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_ERROR: begin
                w_state_next = c_ST_ERROR;
            end
            default: begin
                w_state_next = c_ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Rejected pairs leave the previous thresholds untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_umbral_alto <= c_ALTO_DEF;
            r_umbral_bajo <= c_BAJO_DEF;
            r_th_invalid  <= 1'b0;
        end else begin
            r_th_invalid <= w_reject;
            if (w_load) begin
                r_umbral_alto <= umbral_alto_in;
                r_umbral_bajo <= umbral_bajo_in;
            end
        end
    end

    // Captured only on the entering edge; ERROR never re-samples it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error_idx <= '0;
        end else if (w_err_entry) begin
            r_error_idx <= w_lowest_err;
        end
    end

    assign state       = r_state;
    assign umbral_alto = r_umbral_alto;
    assign umbral_bajo = r_umbral_bajo;
    assign error_idx   = r_error_idx;
    assign th_invalid  = r_th_invalid;
    assign IDLE        = (r_state == c_ST_IDLE);
    assign active      = (r_state == c_ST_ACTIVE);
    assign error_out   = (r_state == c_ST_ERROR);

endmodule
`default_nettype wire
